multiplier_seq_ctrl: RTL and testbench

Sequencing controller for the shift-add/subtract signed multiplier datapath (A:B product register, add/sub/shift strobes). Converts a run request into exactly WIDTH add-or-subtract/shift iterations. The last iteration subtracts, giving two's-complement multiplication. Issues the clear-A strobe at the start of each multiply and gates clear/load requests while busy. Sits between the top-level switches/buttons and the datapath, replacing ad-hoc strobe generation.

---
 rtl/multiplier_seq_ctrl.sv | 116 +++++++++++
 tb/tb_multiplier_seq_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_seq_ctrl.sv
// Sequencing controller for a shift-add/subtract signed multiplier datapath.
// Optional 2-flop input synchronizers on run/clr_ld_req: define MULT_RUN_SYNC_EN.
`timescale 1ns/1ps
module multiplier_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             clr_ld_req,
  input  logic             m_bit,
  output logic             clear_a,
  output logic             clr_ld,
  output logic             add,
  output logic             sub,
  output logic             shift,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter
);

  // One-hot so every Moore output is a single flop bit (no decode glitches).
  localparam int B_IDLE  = 0;
  localparam int B_CLRA  = 1;
  localparam int B_EVAL  = 2;
  localparam int B_SHIFT = 3;
  localparam int B_DONE  = 4;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    CLRA  = 5'b00010,
    EVAL  = 5'b00100,
    SHIFT = 5'b01000,
    DONE  = 5'b10000
  } state_e;

  localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(WIDTH-1);
  localparam logic [CNT_W-1:0] ITER_MAX = CNT_W'(WIDTH);

  state_e           state, state_nxt;
  logic [4:0]       st;
  logic [CNT_W-1:0] iter_q, iter_nxt, iter_inc;
  logic             run_s, clr_s;

`ifdef MULT_RUN_SYNC_EN
  logic [1:0] run_sync, clr_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_sync <= '0;
      clr_sync <= '0;
    end else begin
      run_sync <= {run_sync[0], run};
      clr_sync <= {clr_sync[0], clr_ld_req};
    end
  end

  assign run_s = run_sync[1];
  assign clr_s = clr_sync[1];
`else
  // Combinational pass-through; held off while reset is asserted.
  assign run_s = run;
  assign clr_s = clr_ld_req & reset_n;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      iter_q <= '0;
    end else begin
      state  <= state_nxt;
      iter_q <= iter_nxt;
    end
  end

  assign iter_inc = iter_q + CNT_W'(1);

  always_comb begin
    state_nxt = state;
    iter_nxt  = iter_q;
    unique case (state)
      IDLE:  if (run_s) state_nxt = CLRA;
      CLRA: begin
        iter_nxt  = '0;
        state_nxt = EVAL;
      end
      EVAL:  state_nxt = SHIFT;
      SHIFT: begin
        iter_nxt  = iter_inc;
        state_nxt = (iter_inc == ITER_MAX) ? DONE : EVAL;
      end
      // Level-sensitive exit: a held run cannot retrigger from DONE.
      DONE:  if (!run_s) state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        iter_nxt  = '0;
      end
    endcase
  end

  assign st = state;

  assign clear_a = st[B_CLRA];
  assign shift   = st[B_SHIFT];
  assign busy    = st[B_CLRA] | st[B_EVAL] | st[B_SHIFT];
  assign done    = st[B_DONE];
  assign iter    = iter_q;

  // Final iteration subtracts to weight the multiplier sign bit negatively.
  assign add = st[B_EVAL] & m_bit & (iter_q <  LAST_IT);
  assign sub = st[B_EVAL] & m_bit & (iter_q == LAST_IT);

  assign clr_ld = clr_s & (st[B_IDLE] | st[B_DONE]);

endmodule

// File: tb/tb_multiplier_seq_ctrl.sv
// Scoreboard bench: stimulus queues expected products/strobe masks, a monitor
// checks them against a behavioural X:A:B datapath whenever done rises.
`timescale 1ns/1ps
module tb_multiplier_seq_ctrl;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
`ifdef MULT_RUN_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic clk = 1'b0, reset_n = 1'b0, run = 1'b0, clr_ld_req = 1'b0, m_bit;
  logic clear_a, clr_ld, add, sub, shift, busy, done;
  logic [CNT_W-1:0] iter;

  multiplier_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .clr_ld_req(clr_ld_req), .m_bit(m_bit),
    .clear_a(clear_a), .clr_ld(clr_ld), .add(add), .sub(sub), .shift(shift),
    .busy(busy), .done(done), .iter(iter)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Behavioural datapath: X:A:B with multiplicand S and switch input sw.
  logic [7:0] ma = '0, mb = '0, ms = '0, sw = '0;
  logic       mx = 1'b0, force_m0 = 1'b0;
  assign m_bit = force_m0 ? 1'b0 : mb[0];

  always @(posedge clk) begin
    if (clr_ld) mb <= sw;
    if (clear_a) begin ma <= '0; mx <= 1'b0; end
    if (add) {mx, ma} <= {ma[7], ma} + {ms[7], ms};
    if (sub) {mx, ma} <= {ma[7], ma} - {ms[7], ms};
    if (shift) begin
      ma <= {mx, ma[7:1]};
      mb <= {ma[0], mb[7:1]};
    end
  end

  typedef struct {
    logic [15:0] prod;
    logic [7:0]  am;
    logic [7:0]  sm;
    int          dcyc;
  } exp_t;
  exp_t q[$];

  // Monitor
  logic [7:0] am_acc = '0, sm_acc = '0;
  int busy_n = 0, shift_n = 0, clra_n = 0, clra_total = 0;
  logic both = 1'b0, done_q = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!reset_n) begin
        am_acc = '0; sm_acc = '0; busy_n = 0; shift_n = 0; clra_n = 0;
        both = 1'b0; done_q = 1'b0;
      end else begin
        if (clear_a) begin clra_n++; clra_total++; end
        if (add) am_acc[iter[2:0]] = 1'b1;
        if (sub) sm_acc[iter[2:0]] = 1'b1;
        if (add && sub) both = 1'b1;
        if (busy) busy_n++;
        if (shift) shift_n++;
        if (done && !done_q) begin
          if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
          else begin
            e = q.pop_front();
            chk("product",   {16'd0, ma, mb}, {16'd0, e.prod});
            chk("add_mask",  {24'd0, am_acc}, {24'd0, e.am});
            chk("sub_mask",  {24'd0, sm_acc}, {24'd0, e.sm});
            chk("done_iter", {28'd0, iter}, 32'd8);
            chk("done_cyc",  32'(cyc), 32'(e.dcyc));
            chk("busy_len",  32'(busy_n), 32'd17);
            chk("shifts",    32'(shift_n), 32'd8);
            chk("clear_a_n", 32'(clra_n), 32'd1);
            chk("add_sub_excl", {31'd0, both}, 32'd0);
          end
          am_acc = '0; sm_acc = '0; busy_n = 0; shift_n = 0; clra_n = 0; both = 1'b0;
        end
        done_q = done;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input logic push, input logic [15:0] prod,
                       input logic [7:0] am, input logic [7:0] sm);
    @(negedge clk);
    run = 1'b1; clr_ld_req = 1'b1;
    if (push) q.push_back('{prod, am, sm, cyc + 18 + SL});
    @(negedge clk);
    clr_ld_req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk); #1;
      if (done) ok = 1;
    end
    if (!ok) chk(name, 32'd0, 32'd1);
  endtask

  task automatic wait_eval_iter(input int it, input string name);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk); #1;
      if (busy && !shift && !clear_a && 32'(iter) == it) ok = 1;
    end
    if (!ok) chk(name, 32'd0, 32'd1);
  endtask

  // Pulse clr_ld_req for one cycle and check the forwarded strobe where it lands.
  task automatic pulse_clr(input string name, input logic exp);
    clr_ld_req = 1'b1; #1;
`ifndef MULT_RUN_SYNC_EN
    chk(name, {31'd0, clr_ld}, {31'd0, exp});
`endif
    @(negedge clk);
    clr_ld_req = 1'b0;
`ifdef MULT_RUN_SYNC_EN
    @(negedge clk); #1;
    chk(name, {31'd0, clr_ld}, {31'd0, exp});
`endif
  endtask

  task automatic release_run(input string name);
    @(negedge clk);
    run = 1'b0;
    repeat (1 + SL) @(negedge clk);
    #1 chk(name, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int fc, fa, saved;
    // Reset state
    #1 chk("reset_outs", {24'd0, clear_a, clr_ld, add, sub, shift, busy, done, 1'b0}, 32'd0);
    chk("reset_iter", {28'd0, iter}, 32'd0);
    tick(2); #2 reset_n = 1'b1;
    tick(2);

    // m_bit held 0: no add/sub, done holds while run high
    force_m0 = 1'b1; sw = 8'h5A; ms = 8'h33;
    start(1'b1, 16'h0000, 8'h00, 8'h00);
    wait_done("t2_timeout");
    tick(3); #1 chk("t2_done_hold", {31'd0, done}, 32'd1);
    release_run("t2_idle");
    force_m0 = 1'b0;
    tick(2);

    // Asynchronous reset mid-EVAL at iter 3
    sw = 8'hFF; ms = 8'h01;
    start(1'b0, 16'h0, 8'h0, 8'h0);
    wait_eval_iter(3, "t1_timeout");
    chk("t1_pre_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0; run = 1'b0; #1;
    chk("t1_async_outs", {24'd0, clear_a, clr_ld, add, sub, shift, busy, done, 1'b0}, 32'd0);
    chk("t1_async_iter", {28'd0, iter}, 32'd0);
    tick(3); #2 reset_n = 1'b1;
    tick(3); #1;
    chk("t1_post_idle", {30'd0, busy, done}, 32'd0);
    chk("t1_post_iter", {28'd0, iter}, 32'd0);

    // 7 * -3 with run and clr_ld_req rising together in IDLE
    @(negedge clk);
    ms = 8'h07; sw = 8'hFD; run = 1'b1; clr_ld_req = 1'b1;
    q.push_back('{16'hFFEB, 8'h7D, 8'h80, cyc + 18 + SL});
    fc = -1; fa = -1;
    for (int n = 0; n < 8; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 1) clr_ld_req = 1'b0;
      #1;
      if (clr_ld && fc < 0) fc = n;
      if (clear_a && fa < 0) fa = n;
    end
    chk("t6_clr_ld_at", 32'(fc), 32'(SL));
    chk("t6_clear_a_at", 32'(fa), 32'(SL + 1));
    wait_done("t3_timeout");
    saved = clra_total;
    tick(25); #1;
    chk("t4_held_done", {31'd0, done}, 32'd1);
    chk("t4_no_restart", 32'(clra_total), 32'(saved));
    release_run("t3_idle");
    tick(2);

    // -7 * -3, with clr_ld_req gating checks while busy and in DONE
    ms = 8'hF9; sw = 8'hFD;
    start(1'b1, 16'h0015, 8'h7D, 8'h80);
    wait_eval_iter(4, "t5_timeout");
    sw = 8'h11;
    pulse_clr("t5_gate_busy", 1'b0);
    wait_done("t4_timeout");
    tick(1);
    pulse_clr("t5_pass_done", 1'b1);
    release_run("t4_idle");

    tick(4);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
